// File: rtl/alu_unit.sv
// Single-cycle ALU with HI/LO registers for multiply and move-to/from results.
// Optional divide support is enabled by defining ALU_DIVIDE_EN.
module alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluParamData1,
  input  logic [31:0] aluParamData2,
  input  logic [4:0]  ALUControl,
  output logic        zero,
  output logic [31:0] aluResult
);

  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 64;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_NOR  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b01001;
  localparam logic [4:0] OP_SRL  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_LUI  = 5'b01100;
  localparam logic [4:0] OP_MULT = 5'b01101;
  localparam logic [4:0] OP_MULTU= 5'b01110;
  localparam logic [4:0] OP_MFHI = 5'b01111;
  localparam logic [4:0] OP_MFLO = 5'b10000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10010;
`ifdef ALU_DIVIDE_EN
  localparam logic [4:0] OP_DIV  = 5'b10011;
  localparam logic [4:0] OP_DIVU = 5'b10100;
`endif

  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  hi_nxt, lo_nxt;
  logic [W2-1:0] prod_s, prod_u;

  assign a     = aluParamData1;
  assign b     = aluParamData2;
  assign shamt = a[4:0];

  // Operands are extended to full product width before multiplying.
  assign prod_s = W2'($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}));
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

`ifdef ALU_DIVIDE_EN
  logic [W-1:0] divisor;
  logic [W-1:0] quot_s, rem_s, quot_u, rem_u;

  // Substitute a harmless divisor when B is zero; results are discarded then.
  assign divisor = (b == '0) ? W'(1) : b;
  assign quot_s  = W'($signed(a) / $signed(divisor));
  assign rem_s   = W'($signed(a) % $signed(divisor));
  assign quot_u  = a / divisor;
  assign rem_u   = a % divisor;
`endif

  // Result mux and next HI/LO values.
  always_comb begin
    aluResult = '0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (ALUControl)
      OP_AND:   aluResult = a & b;
      OP_OR:    aluResult = a | b;
      OP_ADD:   aluResult = a + b;
      OP_XOR:   aluResult = a ^ b;
      OP_NOR:   aluResult = ~(a | b);
      OP_SUB:   aluResult = a - b;
      OP_SLT:   aluResult = W'($signed(a) < $signed(b));
      OP_SLTU:  aluResult = W'(a < b);
      OP_SLL:   aluResult = b << shamt;
      OP_SRL:   aluResult = b >> shamt;
      OP_SRA:   aluResult = W'($signed(b) >>> shamt);
      OP_LUI:   aluResult = {b[15:0], 16'h0000};
      OP_MULT: begin
        aluResult = prod_s[W-1:0];
        hi_nxt    = prod_s[W2-1:W];
        lo_nxt    = prod_s[W-1:0];
      end
      OP_MULTU: begin
        aluResult = prod_u[W-1:0];
        hi_nxt    = prod_u[W2-1:W];
        lo_nxt    = prod_u[W-1:0];
      end
      OP_MFHI:  aluResult = hi;
      OP_MFLO:  aluResult = lo;
      OP_MTHI: begin
        aluResult = a;
        hi_nxt    = a;
      end
      OP_MTLO: begin
        aluResult = a;
        lo_nxt    = a;
      end
`ifdef ALU_DIVIDE_EN
      OP_DIV: begin
        if (b != '0) begin
          aluResult = quot_s;
          lo_nxt    = quot_s;
          hi_nxt    = rem_s;
        end
      end
      OP_DIVU: begin
        if (b != '0) begin
          aluResult = quot_u;
          lo_nxt    = quot_u;
          hi_nxt    = rem_u;
        end
      end
`endif
      default:  aluResult = '0;
    endcase
  end

  assign zero = (aluResult == '0);

  // HI/LO state; reset wins over any same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit: combinational vector table plus
// HI/LO sequences (multiply, moves, reset priority, unassigned/divide opcodes).
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [4:0]  ctl;
  logic        zero;
  logic [31:0] res;

  int tests;
  int fails;

  alu_unit dut (
    .clk          (clk),
    .reset        (reset),
    .aluParamData1(a),
    .aluParamData2(b),
    .ALUControl   (ctl),
    .zero         (zero),
    .aluResult    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  localparam int unsigned NV = 17;
  vec_t vecs [NV];

  // Inputs change at the falling edge so each drive is followed by one rising edge.
  task automatic drive(input logic [4:0] c, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    ctl = c;
    a   = va;
    b   = vb;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_z);
    tests++;
    if (res !== exp_res || zero !== exp_z) begin
      fails++;
      $display("FAIL %s: got result=%08h zero=%b, want result=%08h zero=%b",
               name, res, zero, exp_res, exp_z);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    ctl   = 5'b11111;
    a     = '0;
    b     = '0;

    vecs[0]  = '{"and",      5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[1]  = '{"or",       5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vecs[2]  = '{"add",      5'b00010, 32'h00400000, 32'h00000004, 32'h00400004, 1'b0};
    vecs[3]  = '{"add_wrap", 5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[4]  = '{"xor",      5'b00011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[5]  = '{"nor",      5'b00100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"sub_eq",   5'b00110, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1};
    vecs[7]  = '{"sub_wrap", 5'b00110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{"slt",      5'b00111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[9]  = '{"sltu",     5'b01000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[10] = '{"sll",      5'b01001, 32'h00000024, 32'h00000001, 32'h00000010, 1'b0};
    vecs[11] = '{"srl",      5'b01010, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
    vecs[12] = '{"sra",      5'b01011, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
    vecs[13] = '{"sra31",    5'b01011, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0};
    vecs[14] = '{"lui",      5'b01100, 32'h12345678, 32'h0001ABCD, 32'hABCD0000, 1'b0};
    vecs[15] = '{"op00101",  5'b00101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[16] = '{"op11111",  5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};

    // Reset clears HI/LO.
    repeat (2) @(posedge clk);
    drive(5'b01111, 32'h0, 32'h0);
    reset = 1'b0;
    drive(5'b01111, 32'h0, 32'h0);
    check("rst_mfhi", 32'h0, 1'b1);
    drive(5'b10000, 32'h0, 32'h0);
    check("rst_mflo", 32'h0, 1'b1);

    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].ctl, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].res, vecs[i].z);
    end

    // Signed multiply -2 * 3.
    drive(5'b01101, 32'hFFFFFFFE, 32'h00000003);
    check("mult_res", 32'hFFFFFFFA, 1'b0);
    drive(5'b01111, 32'h0, 32'h0);
    check("mult_hi", 32'hFFFFFFFF, 1'b0);
    drive(5'b10000, 32'h0, 32'h0);
    check("mult_lo", 32'hFFFFFFFA, 1'b0);

    // Unsigned multiply, same operands, held for two edges.
    drive(5'b01110, 32'hFFFFFFFE, 32'h00000003);
    check("multu_res", 32'hFFFFFFFA, 1'b0);
    @(negedge clk);
    drive(5'b01111, 32'h0, 32'h0);
    check("multu_hi", 32'h00000002, 1'b0);
    drive(5'b10000, 32'h0, 32'h0);
    check("multu_lo", 32'hFFFFFFFA, 1'b0);

    // Unassigned opcode leaves HI/LO alone.
    drive(5'b11111, 32'h12345678, 32'h9ABCDEF0);
    check("op11111_res", 32'h0, 1'b1);
    drive(5'b01111, 32'h0, 32'h0);
    check("op11111_hi", 32'h00000002, 1'b0);

`ifdef ALU_DIVIDE_EN
    drive(5'b10011, 32'hFFFFFFF9, 32'h00000002);
    check("div_res", 32'hFFFFFFFD, 1'b0);
    drive(5'b10000, 32'h0, 32'h0);
    check("div_lo", 32'hFFFFFFFD, 1'b0);
    drive(5'b01111, 32'h0, 32'h0);
    check("div_hi", 32'hFFFFFFFF, 1'b0);
    drive(5'b10011, 32'h00000009, 32'h00000000);
    check("div0_res", 32'h0, 1'b1);
    drive(5'b10000, 32'h0, 32'h0);
    check("div0_lo", 32'hFFFFFFFD, 1'b0);
    drive(5'b01111, 32'h0, 32'h0);
    check("div0_hi", 32'hFFFFFFFF, 1'b0);
`else
    drive(5'b10011, 32'hFFFFFFF9, 32'h00000002);
    check("div_res", 32'h0, 1'b1);
    drive(5'b10100, 32'hFFFFFFF9, 32'h00000002);
    check("divu_res", 32'h0, 1'b1);
    drive(5'b10000, 32'h0, 32'h0);
    check("div_lo", 32'hFFFFFFFA, 1'b0);
    drive(5'b01111, 32'h0, 32'h0);
    check("div_hi", 32'h00000002, 1'b0);
`endif

    // MTLO then MFLO.
    drive(5'b10010, 32'h00000005, 32'h0);
    check("mtlo_res", 32'h00000005, 1'b0);
    drive(5'b10000, 32'h0, 32'h0);
    check("mtlo_lo", 32'h00000005, 1'b0);

    // MTHI, then reset with a same-edge MTLO: reset wins.
    drive(5'b10001, 32'hDEADBEEF, 32'h0);
    check("mthi_res", 32'hDEADBEEF, 1'b0);
    drive(5'b01111, 32'h0, 32'h0);
    check("mthi_hi", 32'hDEADBEEF, 1'b0);
    drive(5'b10010, 32'h00000005, 32'h0);
    reset = 1'b1;
    drive(5'b01111, 32'h0, 32'h0);
    reset = 1'b0;
    check("rst2_mfhi", 32'h0, 1'b1);
    drive(5'b10000, 32'h0, 32'h0);
    check("rst2_mflo", 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
